rsa_mont_mult: RTL
==================

// Module: rsa_mont_mult
//
// PURPOSE
// - Bit-serial radix-2 Montgomery modular multiplier.
// - Computes result = a * b * 2^(-WIDTH) mod p.
// - It is the arithmetic core driven by the RSA modular-exponentiation sequencer, which sits
//   behind the SPI register file (P, E, M, Const).
// - The sequencer issues one multiply per start/done handshake, chaining squares and
//   multiplies. Const (R^2 mod p) moves operands into and out of the Montgomery domain.
//
// PARAMETERS
// - WIDTH  7  Operand, modulus and result width in bits. Legal range is WIDTH >= 2.
//
// PORTS
// - clk     in   1      Rising-edge clock.
// - rst     in   1      Synchronous reset, active-high.
// - en      in   1      Clock enable. While 0, every register holds its value (done included).
// - start   in   1      Request a multiply. Sampled only in IDLE with en=1.
// - a       in   WIDTH  Multiplicand. Requires a < p. Latched on start acceptance.
// - b       in   WIDTH  Multiplier. Requires b < p. Latched on start acceptance.
// - p       in   WIDTH  Modulus. Must be odd, p >= 3. Latched on start acceptance.
// - busy    out  1      High while a multiply is in progress (state != IDLE).
// - done    out  1      One-cycle pulse (while en=1). Marks the edge on which result is updated.
// - result  out  WIDTH  Last completed product, always < p. Holds until the next done.
//
// BEHAVIOUR
// - Reset (rst=1 at an edge, regardless of en): state=IDLE, busy=0, done=0, result=0,
//   S=0, cnt=0.
// - Internal registers:
//   - ra, rb, rp: latched operands, WIDTH bits each.
//   - S: accumulator, WIDTH+2 bits. No overflow is possible because S < 2p always holds.
//   - cnt: bit index, clog2(WIDTH) bits.
// - All updates below apply only on edges where en=1 and rst=0.
// - FSM IDLE:
//   - done <= 0.
//   - If start: latch a, b, p; S <= 0; cnt <= 0; go to RUN.
//   - Otherwise stay in IDLE.
// - FSM RUN (one iteration per edge; bit i = cnt):
//   - t = S + (ra[i] ? rb : 0)
//   - q = t[0]
//   - S <= (t + (q ? rp : 0)) >> 1
//   - cnt <= cnt + 1
//   - When cnt == WIDTH-1, go to CORR.
// - FSM CORR:
//   - result <= (S >= rp) ? S - rp : S (truncated to WIDTH bits).
//   - done <= 1; go to IDLE.
// - Latency: start is sampled at edge E0. The RUN iterations occur on edges E1..E_WIDTH.
//   done and result update at edge E_(WIDTH+1).
// - busy: goes 1 after E0 and returns to 0 after E_(WIDTH+1), at the same edge done rises.
// - Throughput: one multiply per WIDTH+2 edges. Back-to-back operation is allowed:
//   - A start held high in the cycle where done=1 is accepted (the FSM is in IDLE).
//   - That edge clears done.
// - start while busy=1 is ignored. It is neither queued nor allowed to disturb the
//   latched operands.
// - Operand inputs may change freely after acceptance. Only the latched copies are used.
// - en=0 mid-operation: the operation freezes, then resumes exactly where it stopped.
//   The result equals the result of an uninterrupted run; only the latency grows.
// - rst mid-operation: the operation is aborted and all reset values above apply on that edge.
//   No done is emitted for the aborted operation.
// - Precondition violations (even p, a >= p, b >= p):
//   - result is unspecified, but it is still WIDTH bits wide.
//   - The FSM still completes in WIDTH+2 edges and never hangs.
//
// TESTING (WIDTH=8 unless noted; en=1 unless noted)
// - Reset: assert rst for 2 cycles.
//   -> busy=0, done=0, result=0. A start pulse issued during rst is ignored.
// - Basic, p=251 (2^-8 mod 251 = 201):
//   - a=5,   b=1   -> result=1.
//   - a=250, b=250 -> result=201.
//   - a=0,   b=123 -> result=0.
//   - For each case, done is high exactly 9 edges after start is sampled, for 1 cycle.
// - Boundary, p=255 (2^8 = 1 mod 255):
//   - a=254, b=254 -> result=1.
//   - a=16,  b=16  -> result=1.
//   - a=1,   b=0   -> result=0.
//   - These cases exercise the S >= p correction path and the maximum modulus.
// - Handshake:
//   - Pulse start again 3 cycles after acceptance with different a, b. It must be ignored:
//     the result matches the first operands and busy stays high continuously.
//   - Hold start high through done. A second multiply is accepted on the done edge, with
//     busy low for that single cycle.
// - Stall and abort:
//   - Drop en for 5 cycles mid-RUN with p=251, a=250, b=250. Then done arrives 5 cycles
//     late and result=201.
//   - Assert rst mid-RUN. No done follows, and result=0.
// - Randomised: 10k random odd p, with a and b uniformly drawn below p, for WIDTH=7 and
//   WIDTH=8.
//   - Compare against a reference model (a*b*inv(2^WIDTH) mod p).
//   - Assert result < p at every done.

Source files
------------

// File: rtl/rsa_mont_mult_if.sv
// Handshake and operand bundle between the exponentiation sequencer
// and the bit-serial Montgomery multiplier.
interface rsa_mont_mult_if #(
    parameter int WIDTH = 7
) ();
    logic             en;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output en, start, a, b, p,
        input  busy, done, result
    );

    modport slave (
        input  en, start, a, b, p,
        output busy, done, result
    );
endinterface

// File: rtl/rsa_mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod p.
// One operand bit per cycle, then a single conditional-subtract step.
module rsa_mont_mult #(
    parameter int WIDTH = 7
) (
    input  logic           clk,
    input  logic           rst,
    rsa_mont_mult_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CORR
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rp_q, rp_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [SW-1:0]    t;
    logic [SW-1:0]    u;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            rp_q     <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (bus.en) begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rp_q     <= rp_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (cnt_q == LAST) state_d = CORR;
            CORR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // S stays below 2p, so t < 3p and t + p < 4p fit in WIDTH+2 bits
    always_comb begin
        t = s_q + (ra_q[cnt_q] ? {2'b00, rb_q} : '0);
        u = t + (t[0] ? {2'b00, rp_q} : '0);
    end

    always_comb begin
        ra_d     = ra_q;
        rb_d     = rb_q;
        rp_d     = rp_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (bus.start) begin
                    ra_d  = bus.a;
                    rb_d  = bus.b;
                    rp_d  = bus.p;
                    s_d   = '0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                s_d   = u >> 1;
                cnt_d = cnt_q + CW'(1);
            end
            CORR: begin
                if (s_q >= {2'b00, rp_q})
                    result_d = WIDTH'(s_q - {2'b00, rp_q});
                else
                    result_d = s_q[WIDTH-1:0];
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy   = (state_q != IDLE);
        bus.done   = done_q;
        bus.result = result_q;
    end
endmodule
